// File: rtl/montacargas_pkg.sv
// Shared types and constants for the three-floor freight-elevator controller.
package montacargas_pkg;

  typedef enum logic [2:0] {
    P1, P2, P3, SUBIR_P2, SUBIR_P3, BAJAR_P1, BAJAR_P2
  } state_e;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b01;
  localparam logic [1:0] MOTOR_DOWN = 2'b10;

  typedef logic [3:0] glyph_t;

  localparam glyph_t GL_1     = 4'd1;
  localparam glyph_t GL_2     = 4'd2;
  localparam glyph_t GL_3     = 4'd3;
  localparam glyph_t GL_U     = 4'd4;
  localparam glyph_t GL_D     = 4'd5;
  localparam glyph_t GL_DASH  = 4'd6;
  localparam glyph_t GL_BLANK = 4'd7;

  // Segment order {a,b,c,d,e,f,g}, active-low for a common-anode display.
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic btn1;
    logic btn2;
    logic btn3;
    logic door_closed;
    logic fc1;
    logic fc2;
    logic fc3;
  } board_in_t;

  function automatic logic [6:0] glyph_seg(input glyph_t g);
    case (g)
      GL_1:    return SEG_1;
      GL_2:    return SEG_2;
      GL_3:    return SEG_3;
      GL_U:    return SEG_U;
      GL_D:    return SEG_D;
      GL_DASH: return SEG_DASH;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic glyph_t floor_glyph(input logic [1:0] f);
    case (f)
      2'd2:    return GL_2;
      2'd3:    return GL_3;
      default: return GL_1;
    endcase
  endfunction

endpackage

// File: rtl/montacargas_display_mux.sv
// Three-digit multiplexed 7-segment driver; one digit lit per DIV-cycle slot.
module montacargas_display_mux
  import montacargas_pkg::*;
#(
  parameter int DIV = 4000
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  glyph_t [2:0] glyph,
  output logic   [6:0] seg,
  output logic   [2:0] en
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       en_q, en_d;

  // Outputs are registered from the digit index, so the lit digit lags idx_q by one cycle.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
    seg_d = glyph_seg(glyph[idx_q]);
    case (idx_q)
      2'd1:    en_d = 3'b101;
      2'd2:    en_d = 3'b011;
      default: en_d = 3'b110;
    endcase
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_BLANK;
      en_q  <= 3'b110;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      en_q  <= en_d;
    end
  end

  assign seg = seg_q;
  assign en  = en_q;

endmodule

// File: rtl/montacargas_controller.sv
// Freight-elevator controller: synchronizers, 1 s prescaler, idle return timer,
// floor FSM and status display.
module montacargas_controller
  import montacargas_pkg::*;
#(
  parameter int CLK_HZ = 4000000,
  parameter int IDLE_S = 60,
  parameter int MUX_HZ = 1000
) (
  input  logic       clockBase_4MHz,
  input  logic       reset,
  input  logic       BotonPiso1,
  input  logic       BotonPiso2,
  input  logic       BotonPiso3,
  input  logic       SensorPuertaCerrada,
  input  logic       FinalCarreraPiso1,
  input  logic       FinalCarreraPiso2,
  input  logic       FinalCarreraPiso3,
  output logic [1:0] DriverMotor,
  output logic [6:0] SieteSegmentos,
  output logic [2:0] HabilitaDisplay
);

  localparam int PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int TMR_W   = (IDLE_S > 0) ? $clog2(IDLE_S + 1) : 1;
  localparam int MUX_DIV = (CLK_HZ / MUX_HZ > 0) ? CLK_HZ / MUX_HZ : 1;

  board_in_t        raw_in;
  board_in_t        sync0_q, sync0_d, sync1_q, sync1_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       last_q, last_d;
  state_e           state_q, state_d;
  logic             tick, timeout, door;
  logic [1:0]       motor;
  glyph_t [2:0]     glyph;

  assign raw_in = {BotonPiso1, BotonPiso2, BotonPiso3, SensorPuertaCerrada,
                   FinalCarreraPiso1, FinalCarreraPiso2, FinalCarreraPiso3};

  always_comb begin
    sync0_d = raw_in;
    sync1_d = sync0_q;
    tick    = (pre_q == PRE_W'(CLK_HZ - 1));
    pre_d   = tick ? '0 : pre_q + 1'b1;
    timeout = (timer_q == TMR_W'(IDLE_S));
    door    = sync1_q.door_closed;

    // Calls only count with the door closed; a valid call beats the idle timeout.
    state_d = state_q;
    case (state_q)
      P1: if (door) begin
        if (sync1_q.btn2)      state_d = SUBIR_P2;
        else if (sync1_q.btn3) state_d = SUBIR_P3;
      end
      P2: if (door) begin
        if (sync1_q.btn1)      state_d = BAJAR_P1;
        else if (sync1_q.btn3) state_d = SUBIR_P3;
        else if (timeout)      state_d = BAJAR_P1;
      end
      P3: if (door) begin
        if (sync1_q.btn1)      state_d = BAJAR_P1;
        else if (sync1_q.btn2) state_d = BAJAR_P2;
        else if (timeout)      state_d = BAJAR_P1;
      end
      SUBIR_P2: if (sync1_q.fc2) state_d = P2;
      SUBIR_P3: if (sync1_q.fc3) state_d = P3;
      BAJAR_P1: if (sync1_q.fc1) state_d = P1;
      BAJAR_P2: if (sync1_q.fc2) state_d = P2;
      default:  state_d = BAJAR_P1;
    endcase

    // Held at zero outside P2/P3, so every arrival there starts from zero.
    timer_d = '0;
    if (state_q == P2 || state_q == P3)
      timer_d = (tick && !timeout) ? timer_q + 1'b1 : timer_q;

    last_d = last_q;
    case (state_d)
      P1:      last_d = 2'd1;
      P2:      last_d = 2'd2;
      P3:      last_d = 2'd3;
      default: last_d = last_q;
    endcase
  end

  always_comb begin
    motor    = MOTOR_STOP;
    glyph[0] = floor_glyph(last_q);
    glyph[1] = GL_BLANK;
    glyph[2] = GL_DASH;
    case (state_q)
      SUBIR_P2: begin motor = MOTOR_UP;   glyph[1] = GL_2; glyph[2] = GL_U; end
      SUBIR_P3: begin motor = MOTOR_UP;   glyph[1] = GL_3; glyph[2] = GL_U; end
      BAJAR_P1: begin motor = MOTOR_DOWN; glyph[1] = GL_1; glyph[2] = GL_D; end
      BAJAR_P2: begin motor = MOTOR_DOWN; glyph[1] = GL_2; glyph[2] = GL_D; end
      default:  motor = MOTOR_STOP;
    endcase
  end

  always_ff @(posedge clockBase_4MHz or negedge reset) begin
    if (!reset) begin
      sync0_q <= '0;
      sync1_q <= '0;
      pre_q   <= '0;
      timer_q <= '0;
      last_q  <= 2'd1;
      state_q <= BAJAR_P1;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      pre_q   <= pre_d;
      timer_q <= timer_d;
      last_q  <= last_d;
      state_q <= state_d;
    end
  end

  assign DriverMotor = motor;

  montacargas_display_mux #(.DIV(MUX_DIV)) u_disp (
    .gclk   (clockBase_4MHz),
    .grst_n (reset),
    .glyph  (glyph),
    .seg    (SieteSegmentos),
    .en     (HabilitaDisplay)
  );

endmodule

// File: tb/tb_montacargas_controller.sv
// Bench for montacargas_controller: floor-position reference model checked every
// cycle, directed scenarios with literal expectations, then randomized inputs.
module tb_montacargas_controller;

  localparam int CLK_HZ = 20;
  localparam int IDLE_S = 3;
  localparam int MUX_HZ = 5;
  localparam int DIV    = CLK_HZ / MUX_HZ;
  localparam int G_U = 10, G_D = 11, G_DASH = 12, G_BLANK = 15;

  logic clk = 1'b0, reset = 1'b0;
  logic b1 = 1'b0, b2 = 1'b0, b3 = 1'b0, spc = 1'b0;
  logic fc1 = 1'b0, fc2 = 1'b0, fc3 = 1'b0;
  logic [1:0] DriverMotor;
  logic [6:0] SieteSegmentos;
  logic [2:0] HabilitaDisplay;

  montacargas_controller #(.CLK_HZ(CLK_HZ), .IDLE_S(IDLE_S), .MUX_HZ(MUX_HZ)) dut (
    .clockBase_4MHz      (clk),
    .reset               (reset),
    .BotonPiso1          (b1),
    .BotonPiso2          (b2),
    .BotonPiso3          (b3),
    .SensorPuertaCerrada (spc),
    .FinalCarreraPiso1   (fc1),
    .FinalCarreraPiso2   (fc2),
    .FinalCarreraPiso3   (fc3),
    .DriverMotor         (DriverMotor),
    .SieteSegmentos      (SieteSegmentos),
    .HabilitaDisplay     (HabilitaDisplay)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  // Model: car is either stopped at m_floor or moving toward m_tgt.
  int   k = 0;
  bit   m_moving = 1'b1, m_up = 1'b0;
  int   m_tgt = 1, m_floor = 1, m_idle = 0, call;
  int   pd [3] = '{0, 0, 0};
  logic [6:0] d1 = '0, d2 = '0, s = '0;

  function automatic logic [6:0] seg_of(input int g);
    case (g)
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      G_U:     return 7'b1000001;
      G_D:     return 7'b1000010;
      G_DASH:  return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  // Inputs take two clocks to reach the controller's decisions.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      k = 0; m_moving = 1'b1; m_up = 1'b0; m_tgt = 1; m_floor = 1; m_idle = 0;
      d1 = '0; d2 = '0;
    end else begin
      pd[0] = m_floor;
      pd[1] = m_moving ? m_tgt : G_BLANK;
      pd[2] = m_moving ? (m_up ? G_U : G_D) : G_DASH;
      k++;
      s = d2; d2 = d1; d1 = {b1, b2, b3, spc, fc1, fc2, fc3};
      if (m_moving) begin
        if (s[3 - m_tgt]) begin m_moving = 1'b0; m_floor = m_tgt; m_idle = 0; end
      end else begin
        call = 0;
        if (s[3])
          for (int f = 1; f <= 3; f++)
            if (call == 0 && s[7 - f] && f != m_floor) call = f;
        if (call != 0) begin
          m_moving = 1'b1; m_up = (call > m_floor); m_tgt = call;
        end else if (m_floor != 1 && s[3] && m_idle == IDLE_S) begin
          m_moving = 1'b1; m_up = 1'b0; m_tgt = 1;
        end else if (m_floor != 1 && (k % CLK_HZ == 0) && m_idle < IDLE_S) begin
          m_idle++;
        end
      end
    end
  end

  int         ci;
  logic [1:0] em;
  logic [2:0] ee;
  logic [6:0] es;
  initial forever begin
    @(negedge clk);
    em = !m_moving ? 2'b00 : (m_up ? 2'b01 : 2'b10);
    if (k == 0) begin
      ee = 3'b110; es = 7'h7f;
    end else begin
      ci = ((k - 1) / DIV) % 3;
      ee = (ci == 0) ? 3'b110 : (ci == 1) ? 3'b101 : 3'b011;
      es = seg_of(pd[ci]);
    end
    chk("motor", 8'(DriverMotor), 8'(em));
    chk("digit_enable", 8'(HabilitaDisplay), 8'(ee));
    chk("segments", 8'(SieteSegmentos), 8'(es));
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_motor(input logic [1:0] want, input int lim, input string name);
    for (int i = 0; i < lim; i++) begin
      if (DriverMotor == want) break;
      run(1);
    end
    chk(name, 8'(DriverMotor), 8'(want));
  endtask

  task automatic wait_digit(input logic [2:0] en, input logic [6:0] seg, input string name);
    run(1);
    for (int i = 0; i < 30; i++) begin
      if (HabilitaDisplay == en) break;
      run(1);
    end
    chk({name, "_en"}, 8'(HabilitaDisplay), 8'(en));
    chk(name, 8'(SieteSegmentos), 8'(seg));
  endtask

  int lim;
  initial begin
    run(3);
    chk("rst_motor", 8'(DriverMotor), 8'h02);
    chk("rst_en", 8'(HabilitaDisplay), 8'h06);
    chk("rst_seg", 8'(SieteSegmentos), 8'h7f);

    // Homing after reset
    reset = 1'b1; spc = 1'b1;
    run(5);  chk("homing", 8'(DriverMotor), 8'h02);
    fc1 = 1'b1;
    run(3);  chk("home_stop", 8'(DriverMotor), 8'h00);
    wait_digit(3'b110, 7'b1001111, "d0_floor1");

    // Up to 3 passing floor 2
    b3 = 1'b1; run(1); b3 = 1'b0; run(2);
    chk("up_start", 8'(DriverMotor), 8'h01);
    fc1 = 1'b0; fc2 = 1'b1;
    run(CLK_HZ); chk("pass_fc2", 8'(DriverMotor), 8'h01);
    fc2 = 1'b0; fc3 = 1'b1;
    run(3);  chk("arrive3", 8'(DriverMotor), 8'h00);
    wait_digit(3'b110, 7'b0000110, "d0_floor3");

    // Idle return from 3
    run(20); chk("idle_hold", 8'(DriverMotor), 8'h00);
    wait_motor(2'b10, 100, "idle_return");
    fc3 = 1'b0; fc1 = 1'b1;
    run(3);  chk("idle_home", 8'(DriverMotor), 8'h00);

    // Timeout with door held open at floor 2
    b2 = 1'b1; run(1); b2 = 1'b0; run(2);
    chk("up_to2", 8'(DriverMotor), 8'h01);
    fc1 = 1'b0; fc2 = 1'b1; spc = 1'b0;
    run(3);  chk("arrive2", 8'(DriverMotor), 8'h00);
    run(80); chk("door_held", 8'(DriverMotor), 8'h00);
    run(20); spc = 1'b1;
    run(3);  chk("door_close_go", 8'(DriverMotor), 8'h02);
    fc2 = 1'b0; fc1 = 1'b1;
    run(3);  chk("home2", 8'(DriverMotor), 8'h00);

    // Door interlock at floor 1
    spc = 1'b0; run(2);
    b3 = 1'b1; run(1); b3 = 1'b0; run(2);
    chk("interlock", 8'(DriverMotor), 8'h00);
    spc = 1'b1; run(2);
    b3 = 1'b1; run(1); b3 = 1'b0; run(2);
    chk("interlock_go", 8'(DriverMotor), 8'h01);
    fc1 = 1'b0; fc3 = 1'b1;
    run(3);  chk("arrive3b", 8'(DriverMotor), 8'h00);

    // Descend with two buttons: floor 1 wins, floor 2 switch ignored
    run(2);
    b1 = 1'b1; b2 = 1'b1; run(1); b1 = 1'b0; b2 = 1'b0; run(2);
    chk("desc_go", 8'(DriverMotor), 8'h02);
    wait_digit(3'b101, 7'b1001111, "d1_target1");
    wait_digit(3'b011, 7'b1000010, "d2_down");
    fc3 = 1'b0; fc2 = 1'b1;
    run(5);  chk("fc2_ignored", 8'(DriverMotor), 8'h02);
    fc2 = 1'b0; fc1 = 1'b1;
    run(3);  chk("desc_home", 8'(DriverMotor), 8'h00);

    // Asynchronous reset while moving up
    b3 = 1'b1; run(1); b3 = 1'b0; run(2);
    chk("pre_reset_up", 8'(DriverMotor), 8'h01);
    fc1 = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_motor", 8'(DriverMotor), 8'h02);
    chk("mid_rst_en", 8'(HabilitaDisplay), 8'h06);
    chk("mid_rst_seg", 8'(SieteSegmentos), 8'h7f);
    run(2); reset = 1'b1;
    run(4);  chk("rehome", 8'(DriverMotor), 8'h02);
    fc1 = 1'b1;
    run(3);  chk("rehome_stop", 8'(DriverMotor), 8'h00);

    // Randomized: alternate busy and quiet button traffic so timeouts occur
    for (int blk = 0; blk < 12; blk++) begin
      lim = (blk % 2 == 0) ? 11 : 399;
      for (int c = 0; c < 200; c++) begin
        b1  = ($urandom_range(0, lim) == 0);
        b2  = ($urandom_range(0, lim) == 0);
        b3  = ($urandom_range(0, lim) == 0);
        spc = ($urandom_range(0, 7) != 0);
        fc1 = ($urandom_range(0, 9) == 0);
        fc2 = ($urandom_range(0, 9) == 0);
        fc3 = ($urandom_range(0, 9) == 0);
        run(1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
